// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a valid/ready handshake.
// Decodes I/S/B/J/U/Z/SHAMT immediates from a 32-bit instruction word, sign- or
// zero-extended to XLEN, and flags the reserved selector 3'b111.
// Optional feature macro: IMM_GEN_SKID_EN adds a skid register and a registered in_ready.
// Without it, in_ready = !out_valid | out_ready.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module imm_gen_stage #(
  parameter int unsigned XLEN  = `DATA_WIDTH,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

`ifdef IMM_GEN_SKID_EN
  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;
`else
  typedef enum logic [1:0] {StEmpty, StBusy} state_e;
`endif

  state_e state_q, state_d;

  logic            in_xfer, out_xfer;
  logic            s;
  logic [XLEN-1:0] new_imm;
  logic            new_err;
  logic            load_main;

  logic [XLEN-1:0]  main_imm_q;
  logic [TAG_W-1:0] main_tag_q;
  logic             main_err_q;

  // Opcode bits never feed any immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[6:0];

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign s        = in_instr[31];

  // Immediate decode of the word currently offered at the input.
  always_comb begin
    new_imm = '0;
    new_err = 1'b0;
    unique case (in_imm_sel)
      3'b000: new_imm = {{(XLEN-12){s}}, in_instr[31:20]};
      3'b001: new_imm = {{(XLEN-12){s}}, in_instr[31:25], in_instr[11:7]};
      3'b010: new_imm = {{(XLEN-12){s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      3'b011: new_imm = {{(XLEN-20){s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      // Upper bits above 30 are copies of instr[31], which covers RV64 LUI/AUIPC.
      3'b100: new_imm = {{(XLEN-31){s}}, in_instr[30:12], 12'b0};
      3'b101: new_imm = {{(XLEN-5){1'b0}}, in_instr[19:15]};
      3'b110: begin
        if (XLEN == 64) new_imm = {{(XLEN-6){1'b0}}, in_instr[25:20]};
        else            new_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
      end
      3'b111: new_err = 1'b1;
      default: new_err = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (in_xfer) state_d = StBusy;
`ifdef IMM_GEN_SKID_EN
      StBusy: begin
        if (in_xfer && !out_xfer)      state_d = StFull;
        else if (!in_xfer && out_xfer) state_d = StEmpty;
      end
      StFull: if (out_xfer) state_d = StBusy;
`else
      StBusy: if (out_xfer && !in_xfer) state_d = StEmpty;
`endif
      default: state_d = StEmpty;
    endcase
  end

  // Handshake outputs; reset masks both so nothing transfers while rst_n is low.
  always_comb begin
    out_valid = rst_n && (state_q != StEmpty);
`ifdef IMM_GEN_SKID_EN
    in_ready  = rst_n && (state_q != StFull);
`else
    in_ready  = rst_n && ((state_q == StEmpty) || out_ready);
`endif
  end

`ifdef IMM_GEN_SKID_EN
  logic             load_skid, load_from_skid;
  logic [XLEN-1:0]  skid_imm_q;
  logic [TAG_W-1:0] skid_tag_q;
  logic             skid_err_q;

  // Route the accepted entry to main or skid, and refill main from skid on drain.
  always_comb begin
    load_main      = in_xfer && ((state_q == StEmpty) || ((state_q == StBusy) && out_xfer));
    load_skid      = in_xfer && (state_q == StBusy) && !out_xfer;
    load_from_skid = out_xfer && (state_q == StFull);
  end

  // Skid register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_imm_q <= '0;
      skid_tag_q <= '0;
      skid_err_q <= 1'b0;
    end else if (load_skid) begin
      skid_imm_q <= new_imm;
      skid_tag_q <= in_tag;
      skid_err_q <= new_err;
    end
  end

  // Main register, drives the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_err_q <= 1'b0;
    end else if (load_from_skid) begin
      main_imm_q <= skid_imm_q;
      main_tag_q <= skid_tag_q;
      main_err_q <= skid_err_q;
    end else if (load_main) begin
      main_imm_q <= new_imm;
      main_tag_q <= in_tag;
      main_err_q <= new_err;
    end
  end
`else
  // in_ready already guarantees main is empty or draining on an input transfer.
  always_comb begin
    load_main = in_xfer;
  end

  // Main register, drives the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_imm_q <= '0;
      main_tag_q <= '0;
      main_err_q <= 1'b0;
    end else if (load_main) begin
      main_imm_q <= new_imm;
      main_tag_q <= in_tag;
      main_err_q <= new_err;
    end
  end
`endif

  assign out_imm = main_imm_q;
  assign out_tag = main_tag_q;
  assign out_err = main_err_q;

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate generator for the rv32i_sc datapath and its pipelined successors. Accepts a full 32-bit instruction word plus an immediate-format selector. Produces an XLEN-wide sign- or zero-extended immediate one cycle later behind a valid/ready handshake. Sits between the decode stage and the execute-stage operand mux, and adds CSR-uimm, shift-amount, RV64 widths and illegal-selector flagging to the I/S/B/J/U formats.

## Interface
- `XLEN`, default `` `DATA_WIDTH `` (32): immediate output width. Legal values are 32 or 64.
- `TAG_W`, default 32: width of the sideband tag passed through with each immediate, e.g. PC or rd.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  stage can accept a word this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_imm_sel`  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z (CSR uimm), 110 SHAMT, 111 reserved.
- `in_tag`  in  TAG_W  sideband, carried unmodified.
- `out_valid`  out  1  output entry valid.
- `out_ready`  in  1  consumer accepts the output this cycle.
- `out_imm`  out  XLEN  generated immediate.
- `out_tag`  out  TAG_W  tag of the entry on `out_imm`.
- `out_err`  out  1  entry was produced from reserved selector 111.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid & in_ready`.
  - An output transfer occurs when `out_valid & out_ready`.
- Immediate formats (s = instr[31], replicated to XLEN):
  - I: {s…, instr[31:20]}
  - S: {s…, instr[31:25], instr[11:7]}
  - B: {s…, instr[7], instr[30:25], instr[11:8], 0}
  - J: {s…, instr[19:12], instr[20], instr[30:21], 0}
  - U: {s…, instr[31:12], 12'b0}. For XLEN=64 bits [63:32] are copies of instr[31], matching RV64 LUI/AUIPC.
  - Z: zero-extended instr[19:15].
  - SHAMT: zero-extended instr[24:20] when XLEN=32; zero-extended instr[25:20] when XLEN=64.
  - 111: `out_imm`=0 and `out_err`=1. For all other selectors `out_err`=0.
- Each entry is computed combinationally from the accepted input and captured with its tag and err bit. The stage never reorders entries.
- `in_imm_sel`, `in_instr` and `in_tag` are ignored when no transfer occurs.
- Storage is a main register (drives the outputs) plus a skid register, tracked by a 3-state FSM:
  - EMPTY: main register empty. `out_valid`=0, `in_ready`=1. An input transfer moves to BUSY.
  - BUSY: main register full, skid empty. `out_valid`=1, `in_ready`=1.
    - Input and output transfer together: main is reloaded, stay in BUSY.
    - Output transfer only: go to EMPTY.
    - Input transfer only (consumer stalled): the new entry goes to skid, go to FULL.
  - FULL: main and skid both full. `out_valid`=1, `in_ready`=0. An output transfer moves skid into main and goes to BUSY.
- While `rst_n`=0:
  - `out_valid`=0, `out_err`=0, `out_imm`=0, `out_tag`=0, and the skid contents are cleared.
  - FSM is forced to EMPTY.
  - `in_ready` is forced to 0. It reads 1 in the first cycle after release.
- Reset asserted mid-operation discards all held entries, including one in the skid register, without producing any output transfer.

## Timing
- Latency: an input accepted at edge N is presented on `out_*` with `out_valid`=1 after edge N, in cycle N+1.
- Throughput: one entry per cycle when `out_ready` is held high.
- `in_ready` is driven from registers only; there is no combinational path from `out_ready` to `in_ready` with the skid feature compiled in.
- `out_*` hold stable while `out_valid & !out_ready`.
- The FULL → BUSY transition and a simultaneous input attempt: the input is not accepted that cycle, because `in_ready`=0.

## Configuration
- Macro: `IMM_GEN_SKID_EN`.
- Defined: the two-entry skid behaviour above applies, with registered `in_ready`.
- Undefined:
  - The skid register and FULL state are removed.
  - `in_ready` = `!out_valid | out_ready` (combinational).
  - Latency and reset behaviour are unchanged; throughput is still one per cycle with no stall.

## Test plan
- I-type: `in_instr`=0xFFF00093, sel 000, `out_ready`=1 → next cycle `out_imm`=0xFFFFFFFF, `out_err`=0.
- S/J/U back-to-back, with `in_valid` held high for 3 cycles:
  - 0xFE20AE23/001 → 0xFFFFFFFC
  - 0xFFDFF06F/011 → 0xFFFFFFFC
  - 0x123450B7/100 → 0x12345000
  - Each appears in consecutive cycles.
- Z and reserved:
  - 0x340FD073/101 → 0x0000001F with `out_err`=0.
  - Any word with sel 111 → `out_imm`=0, `out_err`=1.
- Backpressure (`IMM_GEN_SKID_EN` defined):
  - Setup: `out_ready`=0; offer tags 1, 2, 3 with 0x00100093/000.
  - Required: tags 1 and 2 accepted, `in_ready`=0 next cycle, tag 3 held at the input.
  - Raise `out_ready` → tags 1, 2, 3 are output in order, each with `out_imm`=0x00000001.
- Reset mid-operation: from state FULL, assert `rst_n`=0 for 1 cycle → `out_valid`=0 and `in_ready`=0 during reset, `in_ready`=1 after, no stale tag ever appears.
- XLEN=64: sel 100 with 0x800000B7 → 0xFFFFFFFF80000000; sel 110 with 0x03F0D093 → 0x000000000000003F.
